// File: rtl/err_comp_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : err_comp_acc_pkg
// Description : Shared types and default widths for the error-compensation
//               accumulator (FSM state encoding, parameter defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package err_comp_acc_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_KEEP_MSB = 8;
    localparam int DEF_ACC_W    = 24;
    localparam int DEF_LEN_W    = 8;

    // Saturation ceiling for the default accumulator width
    localparam logic [DEF_ACC_W-1:0] ACC_MAX = {DEF_ACC_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage : err_comp_acc_pkg
`default_nettype wire

// File: rtl/err_comp_acc_sat_add.sv
`default_nettype none
// ============================================================================
// Module      : err_comp_acc_sat_add
// Description : Unsigned ACC_W-bit saturating adder. A sum that reaches or
//               exceeds the all-ones value is clamped to all-ones and flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module err_comp_acc_sat_add
    import err_comp_acc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_ovf
);

    logic [ACC_W:0]   w_full;
    logic [ACC_W-1:0] w_max;

    assign w_max  = {ACC_W{1'b1}};
    // One extra bit keeps the carry so the clamp test is exact
    assign w_full = {1'b0, i_a} + {1'b0, i_b};
    // Reaching the ceiling exactly also counts as saturation
    assign o_ovf  = (w_full >= {1'b0, w_max});
    assign o_sum  = o_ovf ? w_max : w_full[ACC_W-1:0];

endmodule : err_comp_acc_sat_add
`default_nettype wire

// File: rtl/err_comp_acc.sv
`default_nettype none
// ============================================================================
// Module      : err_comp_acc
// Description : Sums a programmed number of rounded error products into a
//               saturating accumulator and hands the total to the MAC output
//               adder over valid/ready, with sticky saturation and format
//               error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module err_comp_acc
    import err_comp_acc_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int KEEP_MSB = DEF_KEEP_MSB,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int LEN_W    = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rounded_error_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  comp_sum,
    output logic              sat,
    output logic              fmt_err,
    output logic              busy
);

    localparam int                c_pad_w   = ACC_W - DATA_W;
    localparam int                c_low_w   = DATA_W - KEEP_MSB;
    localparam logic [LEN_W-1:0]  c_cnt_one = LEN_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_sat;
    logic               r_fmt_err;
    logic [ACC_W-1:0]   w_ext;
    logic [ACC_W-1:0]   w_add_sum;
    logic               w_add_ovf;
    logic               w_fmt_bad;
    logic               w_beat;

    assign w_ext     = {{c_pad_w{1'b0}}, rounded_error_product};
    // Bits below the retained MSBs should have been cleared upstream
    assign w_fmt_bad = |rounded_error_product[c_low_w-1:0];
    assign w_beat    = in_valid && in_ready;

    err_comp_acc_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .i_a   (r_acc),
        .i_b   (w_ext),
        .o_sum (w_add_sum),
        .o_ovf (w_add_ovf)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode; handshake outputs depend on registered state only
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = (len == '0) ? HOLD : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && (r_cnt == c_cnt_one)) w_state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Accumulator, beat counter and sticky flags; results persist in IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sat     <= 1'b0;
            r_fmt_err <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_acc     <= '0;
            r_cnt     <= len;
            r_sat     <= 1'b0;
            r_fmt_err <= 1'b0;
        end else if (w_beat) begin
            r_acc <= w_add_sum;
            r_cnt <= r_cnt - c_cnt_one;
            if (w_add_ovf) r_sat     <= 1'b1;
            if (w_fmt_bad) r_fmt_err <= 1'b1;
        end
    end

    assign comp_sum = r_acc;
    assign sat      = r_sat;
    assign fmt_err  = r_fmt_err;

endmodule : err_comp_acc
`default_nettype wire

// File: tb/tb_err_comp_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_err_comp_acc
// Description : Scoreboard bench for err_comp_acc. Two instances (ACC_W=24 and
//               ACC_W=17) share one stimulus stream; expected results are
//               queued at start and popped by a monitor on each handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_err_comp_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] data;
    logic        out_ready;

    logic        in_ready,  out_valid,  sat,  fmt_err,  busy;
    logic [23:0] comp_sum;
    logic        in_ready2, out_valid2, sat2, fmt_err2, busy2;
    logic [16:0] comp_sum2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int handshakes = 0;

    typedef struct {
        logic [23:0] sum24;
        logic        sat24;
        logic [16:0] sum17;
        logic        sat17;
        logic        fmt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic        prev_valid = 1'b0;
    logic [23:0] prev_sum   = '0;

    err_comp_acc u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready),
        .rounded_error_product(data),
        .out_valid(out_valid), .out_ready(out_ready),
        .comp_sum(comp_sum), .sat(sat), .fmt_err(fmt_err), .busy(busy)
    );

    err_comp_acc #(.ACC_W(17)) u_dut17 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready2),
        .rounded_error_product(data),
        .out_valid(out_valid2), .out_ready(out_ready),
        .comp_sum(comp_sum2), .sat(sat2), .fmt_err(fmt_err2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [23:0] s24, input logic st24,
                                input logic [16:0] s17, input logic st17,
                                input logic f);
        exp_t e;
        e.sum24 = s24; e.sat24 = st24; e.sum17 = s17; e.sat17 = st17; e.fmt = f;
        return e;
    endfunction

    // Monitor: stability while held, scoreboard compare on each handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && prev_valid)
                chk("hold_stable", 32'(comp_sum), 32'(prev_sum));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    handshakes++;
                    chk("comp_sum",   32'(comp_sum),  32'(mon_e.sum24));
                    chk("sat",        32'(sat),       32'(mon_e.sat24));
                    chk("fmt_err",    32'(fmt_err),   32'(mon_e.fmt));
                    chk("valid17",    32'(out_valid2), 32'd1);
                    chk("comp_sum17", 32'(comp_sum2), 32'(mon_e.sum17));
                    chk("sat17",      32'(sat2),      32'(mon_e.sat17));
                    chk("fmt_err17",  32'(fmt_err2),  32'(mon_e.fmt));
                end
            end
            prev_valid = out_valid && !out_ready;
            prev_sum   = comp_sum;
        end
    end

    task automatic do_start(input logic [7:0] n, input exp_t e);
        sb.push_back(e);
        start = 1'b1;
        len   = n;
        @(posedge clk); #1;
        start = 1'b0;
        len   = 8'd0;
    endtask

    task automatic send_beat(input logic [15:0] v);
        bit done  = 1'b0;
        int guard = 0;
        in_valid = 1'b1;
        data     = v;
        while (!done && guard < 50) begin
            done = in_ready;
            @(posedge clk); #1;
            guard++;
        end
        if (!done) chk("beat_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit done  = 1'b0;
        int guard = 0;
        while (!done && guard < 50) begin
            done = out_valid && out_ready;
            @(posedge clk); #1;
            guard++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        rst_n = 1'b0; start = 1'b0; len = 8'd0;
        in_valid = 1'b0; data = 16'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",     32'(busy),      32'd0);
        chk("rst_in_ready", 32'(in_ready),  32'd0);
        chk("rst_out_valid",32'(out_valid), 32'd0);
        chk("rst_comp_sum", 32'(comp_sum),  32'd0);
        chk("rst_flags",    32'({sat, fmt_err}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic sum with latency check
        t0 = cyc;
        do_start(8'd4, mk(24'h011200, 1'b0, 17'h11200, 1'b0, 1'b0));
        chk("basic_busy",     32'(busy),     32'd1);
        chk("basic_in_ready", 32'(in_ready), 32'd1);
        send_beat(16'h1200); send_beat(16'h0100);
        send_beat(16'hFF00); send_beat(16'h0000);
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_lat",   32'(cyc - t0),  32'd5);
        wait_done();
        chk("basic_idle",      32'(busy),     32'd0);
        chk("basic_sum_kept",  32'(comp_sum), 32'h011200);

        // Stalls between beats, then backpressure
        do_start(8'd3, mk(24'h002100, 1'b0, 17'h02100, 1'b0, 1'b0));
        send_beat(16'h0A00);
        repeat (2) @(posedge clk);
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'd1);
        chk("stall_sum",      32'(comp_sum), 32'h000A00);
        send_beat(16'h0B00);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        send_beat(16'h0C00);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done();
        chk("bp_idle", 32'(busy), 32'd0);

        // Saturation on the 17-bit instance only
        do_start(8'd3, mk(24'h02FD00, 1'b0, 17'h1FFFF, 1'b1, 1'b0));
        send_beat(16'hFF00); send_beat(16'hFF00); send_beat(16'hFF00);
        wait_done();

        // Format error, value still added
        do_start(8'd2, mk(24'h000380, 1'b0, 17'h00380, 1'b0, 1'b1));
        send_beat(16'h0180); send_beat(16'h0200);
        wait_done();

        // Zero length: result on the next cycle, flags cleared
        do_start(8'd0, mk(24'h000000, 1'b0, 17'h00000, 1'b0, 1'b0));
        chk("zero_valid", 32'(out_valid), 32'd1);
        wait_done();

        // Start pulsed mid-run must be ignored
        do_start(8'd3, mk(24'h000600, 1'b0, 17'h00600, 1'b0, 1'b0));
        send_beat(16'h0100);
        start = 1'b1; len = 8'd7;
        send_beat(16'h0200);
        start = 1'b0; len = 8'd0;
        send_beat(16'h0300);
        chk("ign_valid", 32'(out_valid), 32'd1);
        wait_done();

        // Reset in the middle of a run
        do_start(8'd4, mk(24'h0, 1'b0, 17'h0, 1'b0, 1'b0));
        send_beat(16'h0180); send_beat(16'h0100);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        chk("mr_busy",      32'({busy, busy2}),           32'd0);
        chk("mr_in_ready",  32'({in_ready, in_ready2}),   32'd0);
        chk("mr_out_valid", 32'({out_valid, out_valid2}), 32'd0);
        chk("mr_comp_sum",  32'(comp_sum),                32'd0);
        chk("mr_comp_sum17",32'(comp_sum2),               32'd0);
        chk("mr_flags",     32'({sat, fmt_err, sat2, fmt_err2}), 32'd0);

        do_start(8'd1, mk(24'h000500, 1'b0, 17'h00500, 1'b0, 1'b0));
        send_beat(16'h0500);
        wait_done();

        @(posedge clk); #1;
        chk("sb_empty",   32'(sb.size()),  32'd0);
        chk("handshakes", 32'(handshakes), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_err_comp_acc
`default_nettype wire
